// File: rtl/isqrt_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_sum_pipe
// Purpose  : Sum of integer square roots over N_CH masked lanes. Each lane
//            runs a W/2-stage pipelined restoring isqrt, followed by a
//            registered pairwise adder tree and a final output register.
//            One argument set per clock, fixed latency LAT.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module isqrt_sum_pipe #(
  parameter int N_CH = 3,
  parameter int W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        arg_vld,
  input  logic [N_CH*W-1:0]           arg,
  input  logic [N_CH-1:0]             arg_mask,
  output logic                        res_vld,
  output logic [W/2+$clog2(N_CH)-1:0] res,
  output logic                        busy
);

  localparam int H   = W / 2;           // root width and isqrt stage count
  localparam int L   = $clog2(N_CH);    // adder tree levels
  localparam int RW  = H + L;           // result width
  localparam int LAT = H + L + 1;       // arg_vld to res_vld latency

  // vld[s] marks a live entry in pipeline stage s; stage LAT-1 is the output.
  logic [LAT-1:0]  vld;
  logic [N_CH-1:0] mask_q [H];
  logic [H-1:0]    root_fin [N_CH];
  logic [RW-1:0]   sum_final;

  // Valid shift register: the only pipeline state cleared by reset besides res.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= '0;
    else        vld <= {vld[LAT-2:0], arg_vld};
  end

  assign res_vld = vld[LAT-1];
  assign busy    = |vld;

  // Lane mask travels alongside the isqrt stages and is applied to the roots.
  always_ff @(posedge clk) begin
    if (arg_vld) mask_q[0] <= arg_mask;
    for (int k = 1; k < H; k++) begin
      if (vld[k-1]) mask_q[k] <= mask_q[k-1];
    end
  end

  // --------------------------------------------------------------------------
  // Restoring isqrt. Stage k appends the next two radicand bits to the
  // remainder and tries to subtract {root, 01}; success sets root bit H-1-k.
  // Register widths grow with k: after stage k the root has k+1 bits and the
  // remainder (<= 2*root) fits k+2 bits, so the subtraction can be done
  // modulo 2^(k+2) without losing information.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < H; k++) begin : g_stg
    logic ld;  // load enable: valid of the stage feeding this one

    if (k == 0) begin : g_ld_first
      assign ld = arg_vld;
    end else begin : g_ld_next
      assign ld = vld[k-1];
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ln
      logic [W-2*k-1:0] src;     // radicand bits not yet consumed, MSB pair first
      logic [k+2:0]     cur;
      logic [k+1:0]     trial;
      logic             ge;
      logic [k:0]       root_d;
      logic [k+1:0]     rem_q;
      logic [k:0]       root_q;

      if (k == 0) begin : g_first
        assign src    = arg[i*W +: W];
        assign cur    = {1'b0, src[W-1 -: 2]};
        assign trial  = 2'b01;
        assign root_d = ge;
      end else begin : g_next
        // Remaining radicand bits move forward with the previous stage's result.
        always_ff @(posedge clk) begin
          if (g_stg[k-1].ld) src <= g_stg[k-1].g_ln[i].src[W-2*k-1:0];
        end
        assign cur    = {g_stg[k-1].g_ln[i].rem_q, src[W-2*k-1 -: 2]};
        assign trial  = {g_stg[k-1].g_ln[i].root_q, 2'b01};
        assign root_d = {g_stg[k-1].g_ln[i].root_q, ge};
      end

      assign ge = (cur >= {1'b0, trial});

      // Trial-subtract result for this stage, held while no valid entry arrives.
      always_ff @(posedge clk) begin
        if (ld) begin
          rem_q  <= ge ? (cur[k+1:0] - trial) : cur[k+1:0];
          root_q <= root_d;
        end
      end

      if (k == H - 1) begin : g_last
        // The final remainder is not needed; only the root continues.
        logic unused_rem;
        assign unused_rem  = ^rem_q;
        assign root_fin[i] = root_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Adder tree. Level 0 is the masked roots (combinational); each later
  // level is registered, adds neighbours pairwise, passes an odd leftover
  // through and grows by one bit.
  // --------------------------------------------------------------------------
  for (genvar j = 0; j <= L; j++) begin : g_lvl
    localparam int CNT = (N_CH + (1 << j) - 1) >> j;
    logic [H+j-1:0] node [CNT];

    if (j == 0) begin : g_leaf
      for (genvar i = 0; i < N_CH; i++) begin : g_in
        assign node[i] = mask_q[H-1][i] ? root_fin[i] : '0;
      end
    end else begin : g_add
      localparam int PCNT = (N_CH + (1 << (j - 1)) - 1) >> (j - 1);
      for (genvar i = 0; i < CNT; i++) begin : g_node
        if (2*i + 1 < PCNT) begin : g_pair
          // Pairwise sum of two nodes from the level below.
          always_ff @(posedge clk) begin
            if (vld[H+j-2]) node[i] <= {1'b0, g_lvl[j-1].node[2*i]}
                                     + {1'b0, g_lvl[j-1].node[2*i+1]};
          end
        end else begin : g_pass
          // Odd leftover node forwarded unchanged, zero-extended.
          always_ff @(posedge clk) begin
            if (vld[H+j-2]) node[i] <= {1'b0, g_lvl[j-1].node[2*i]};
          end
        end
      end
    end
  end

  assign sum_final = g_lvl[L].node[0];

  // Output register: holds the last result between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             res <= '0;
    else if (vld[LAT-2])    res <= sum_final;
  end

endmodule
`default_nettype wire

// File: tb/tb_isqrt_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_isqrt_sum_pipe
// Purpose  : Self-checking bench for isqrt_sum_pipe. Three configurations run
//            side by side (N_CH=3/W=32, N_CH=1/W=8, N_CH=5/W=16) against a
//            cycle-indexed reference model built from plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isqrt_sum_pipe;

  localparam int NI    = 3;
  localparam int DEPTH = 2048;
  localparam int LAT_A = 19;
  localparam int LAT_B = 5;
  localparam int LAT_C = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        a_vld = 1'b0;
  logic [95:0] a_arg = '0;
  logic [2:0]  a_mask = '0;
  logic        a_rvld;
  logic [17:0] a_res;
  logic        a_busy;

  logic        b_vld = 1'b0;
  logic [7:0]  b_arg = '0;
  logic [0:0]  b_mask = '0;
  logic        b_rvld;
  logic [3:0]  b_res;
  logic        b_busy;

  logic        c_vld = 1'b0;
  logic [79:0] c_arg = '0;
  logic [4:0]  c_mask = '0;
  logic        c_rvld;
  logic [10:0] c_res;
  logic        c_busy;

  always #5 clk = ~clk;

  isqrt_sum_pipe #(.N_CH(3), .W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .arg_vld(a_vld), .arg(a_arg), .arg_mask(a_mask),
    .res_vld(a_rvld), .res(a_res), .busy(a_busy));

  isqrt_sum_pipe #(.N_CH(1), .W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .arg_vld(b_vld), .arg(b_arg), .arg_mask(b_mask),
    .res_vld(b_rvld), .res(b_res), .busy(b_busy));

  isqrt_sum_pipe #(.N_CH(5), .W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .arg_vld(c_vld), .arg(c_arg), .arg_mask(c_mask),
    .res_vld(c_rvld), .res(c_res), .busy(c_busy));

  int n_checks;
  int n_errors;
  int cyc;
  int lat [NI];

  // Reference model, indexed by bench cycle number.
  bit              exp_v  [NI][DEPTH];
  longint unsigned exp_r  [NI][DEPTH];
  bit              sent   [NI][DEPTH];
  longint unsigned last_r [NI];

  task automatic check_eq(string tag, longint unsigned got, longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned isqrt_ref(longint unsigned x);
    real             xr;
    longint unsigned r;
    xr = real'(x);
    r  = longint'($floor($sqrt(xr)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic longint unsigned ref_sum(logic [159:0] argv, logic [4:0] m,
                                              int n, int w);
    longint unsigned s;
    longint unsigned x;
    logic [159:0]    sh;
    s = 0;
    for (int i = 0; i < n; i++) begin
      sh = argv >> (i * w);
      x  = sh[63:0] & ((64'd1 << w) - 64'd1);
      if (m[i]) s += isqrt_ref(x);
    end
    return s;
  endfunction

  function automatic longint unsigned rand_word(int w);
    longint unsigned all1;
    longint unsigned r;
    all1 = (64'd1 << w) - 64'd1;
    case ($urandom_range(3))
      0:       return 64'd0;
      1:       return all1;
      2:       return {32'($urandom), 32'($urandom)} & all1;
      default: begin
        r = 64'($urandom) & ((64'd1 << (w / 2)) - 64'd1);
        return (r * r + 64'($urandom_range(2))) & all1;
      end
    endcase
  endfunction

  task automatic rand_inputs(bit v);
    a_vld = v;
    b_vld = v;
    c_vld = v;
    for (int i = 0; i < 3; i++) a_arg[i*32 +: 32] = 32'(rand_word(32));
    b_arg = 8'(rand_word(8));
    for (int i = 0; i < 5; i++) c_arg[i*16 +: 16] = 16'(rand_word(16));
    a_mask = 3'($urandom);
    b_mask = 1'($urandom);
    c_mask = 5'($urandom);
  endtask

  task automatic record(int k, logic v, logic [159:0] argv, logic [4:0] m, int n, int w);
    sent[k][cyc] = v;
    if (v) begin
      exp_v[k][cyc + lat[k]] = 1'b1;
      exp_r[k][cyc + lat[k]] = ref_sum(argv, m, n, w);
    end
  endtask

  task automatic check_inst(int k, string nm, logic v, longint unsigned r, logic b);
    bit eb;
    eb = 1'b0;
    for (int m = cyc - lat[k]; m < cyc; m++) begin
      if (m >= 0 && sent[k][m]) eb = 1'b1;
    end
    if (exp_v[k][cyc]) last_r[k] = exp_r[k][cyc];
    check_eq($sformatf("%s_res_vld@%0d", nm, cyc), 64'(v), 64'(exp_v[k][cyc]));
    check_eq($sformatf("%s_busy@%0d", nm, cyc), 64'(b), 64'(eb));
    check_eq($sformatf("%s_res@%0d", nm, cyc), r, last_r[k]);
  endtask

  // Capture this cycle's inputs into the model, advance one clock, compare.
  task automatic cycle();
    record(0, a_vld, {64'd0, a_arg}, {2'b0, a_mask}, 3, 32);
    record(1, b_vld, {152'd0, b_arg}, {4'b0, b_mask}, 1, 8);
    record(2, c_vld, {80'd0, c_arg}, c_mask, 5, 16);
    @(posedge clk);
    #1;
    cyc++;
    check_inst(0, "a", a_rvld, 64'(a_res), a_busy);
    check_inst(1, "b", b_rvld, 64'(b_res), b_busy);
    check_inst(2, "c", c_rvld, 64'(c_res), c_busy);
  endtask

  task automatic directed(logic [95:0] aa, logic [2:0] am, longint unsigned ae,
                          logic [7:0] ba, logic bm, longint unsigned be,
                          logic [79:0] ca, logic [4:0] cm, longint unsigned ce);
    a_vld = 1'b1; a_arg = aa; a_mask = am;
    b_vld = 1'b1; b_arg = ba; b_mask = bm;
    c_vld = 1'b1; c_arg = ca; c_mask = cm;
    cycle();
    repeat (LAT_A - 1) begin
      rand_inputs(1'b0);
      cycle();
    end
    check_eq("a_dir_vld", 64'(a_rvld), 64'd1);
    check_eq("a_dir_res", 64'(a_res), ae);
    check_eq("b_dir_res", 64'(b_res), be);
    check_eq("c_dir_res", 64'(c_res), ce);
    rand_inputs(1'b0);
    cycle();
  endtask

  task automatic mid_reset();
    a_vld = 1'b0;
    b_vld = 1'b0;
    c_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      last_r[k] = 0;
      for (int m = 0; m < DEPTH; m++) begin
        exp_v[k][m] = 1'b0;
        sent[k][m]  = 1'b0;
      end
    end
    check_eq("rst_a_res", 64'(a_res), 64'd0);
    check_eq("rst_a_vld", 64'(a_rvld), 64'd0);
    check_eq("rst_a_busy", 64'(a_busy), 64'd0);
    check_eq("rst_b_res", 64'(b_res), 64'd0);
    check_eq("rst_c_res", 64'(c_res), 64'd0);
    check_eq("rst_c_busy", 64'(c_busy), 64'd0);
    cycle();
    cycle();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    lat[0]   = LAT_A;
    lat[1]   = LAT_B;
    lat[2]   = LAT_C;
    for (int k = 0; k < NI; k++) last_r[k] = 0;

    // Reset state with idle, changing inputs.
    rand_inputs(1'b0);
    cycle();
    rand_inputs(1'b0);
    cycle();
    rst_n = 1'b1;
    repeat (2) begin
      rand_inputs(1'b0);
      cycle();
    end

    // Directed sets: boundaries, truncation, masking.
    directed({32'd36, 32'd25, 32'd16}, 3'b111, 15,
             8'd255, 1'b1, 15,
             {5{16'hFFFF}}, 5'b11111, 1275);
    directed({3{32'hFFFF_FFFF}}, 3'b111, 196605,
             8'd0, 1'b1, 0,
             {16'd16, 16'd9, 16'd4, 16'd1, 16'd0}, 5'b11111, 10);
    directed({32'd15, 32'd17, 32'd0}, 3'b111, 7,
             8'd99, 1'b1, 9,
             {16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd3}, 5'b10001, 256);
    directed({32'd16, 32'd9, 32'd4}, 3'b101, 6,
             8'd255, 1'b0, 0,
             {5{16'hFFFF}}, 5'b00000, 0);
    directed({32'd16, 32'd9, 32'd4}, 3'b000, 0,
             8'd15, 1'b1, 3,
             {{4{16'hFFFF}}, 16'd65024}, 5'b00001, 254);

    // Back-to-back random stream.
    repeat (100) begin
      rand_inputs(1'b1);
      cycle();
    end

    // Stream with 1-cycle and 5-cycle bubbles.
    repeat (6) begin
      repeat (3) begin rand_inputs(1'b1); cycle(); end
      rand_inputs(1'b0);
      cycle();
      repeat (2) begin rand_inputs(1'b1); cycle(); end
      repeat (5) begin rand_inputs(1'b0); cycle(); end
    end
    repeat (LAT_A + 2) begin
      rand_inputs(1'b0);
      cycle();
    end

    // Reset while sets are in flight; nothing may emerge afterwards.
    repeat (8) begin
      rand_inputs(1'b1);
      cycle();
    end
    mid_reset();
    repeat (LAT_A + 4) begin
      rand_inputs(1'b0);
      cycle();
    end

    // Normal operation resumes after reset.
    repeat (4) begin
      rand_inputs(1'b1);
      cycle();
    end
    repeat (LAT_A + 2) begin
      rand_inputs(1'b0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
